// File: rtl/sdram_burst_scheduler.sv
// Picks the next wrap-4 burst or auto-refresh for the single SDRAM command engine.
// Masters are served round-robin; refresh wins whenever the scheduler is idle.
module sdram_burst_scheduler #(
    parameter int N_MASTERS      = 2,
    parameter int W_MASTER       = 1,
    parameter int W_ADDR         = 25,
    parameter int W_REFRESH_CNT  = 12,
    parameter int W_REFRESH_PEND = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_MASTERS-1:0]          req_valid,
    input  logic [N_MASTERS-1:0]          req_write,
    input  logic [N_MASTERS*W_ADDR-1:0]   req_addr,
    output logic [N_MASTERS-1:0]          req_ready,
    output logic                          cmd_valid,
    input  logic                          cmd_ready,
    output logic                          cmd_refresh,
    output logic                          cmd_write,
    output logic [W_ADDR-1:0]             cmd_addr,
    output logic [W_MASTER-1:0]           cmd_master,
    input  logic                          cmd_done,
    input  logic                          cfg_refresh_en,
    input  logic [W_REFRESH_CNT-1:0]      cfg_refresh_interval,
    output logic [W_REFRESH_PEND-1:0]     refresh_pending,
    output logic                          refresh_overflow,
    output logic [1:0]                    dbg_state
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_BUSY  = 2'd2;
    localparam logic [W_REFRESH_PEND-1:0] PEND_MAX = '1;

    logic [1:0]                state_q, state_d;
    logic [W_MASTER-1:0]       rr_q, rr_d;
    logic                      cmd_refresh_q, cmd_refresh_d;
    logic                      cmd_write_q, cmd_write_d;
    logic [W_ADDR-1:0]         cmd_addr_q, cmd_addr_d;
    logic [W_MASTER-1:0]       cmd_master_q, cmd_master_d;
    logic [W_REFRESH_CNT-1:0]  refresh_cnt_q, refresh_cnt_d;
    logic [W_REFRESH_PEND-1:0] pend_q, pend_d;
    logic                      ovf_q, ovf_d;

    logic                      sel_found;
    logic [W_MASTER-1:0]       sel_idx;
    logic                      sel_write;
    logic [W_ADDR-1:0]         sel_addr;
    logic                      accept;
    logic                      refresh_accept;
    logic                      tick;

    // Handshake: a command transfers on the cycle where cmd_valid && cmd_ready;
    // cmd_* hold steady until then, and req_ready pulses in that same cycle.
    assign accept         = (state_q == S_ISSUE) && cmd_ready;
    assign refresh_accept = accept && cmd_refresh_q;
    assign tick           = cfg_refresh_en && (refresh_cnt_q == '0);

    // Outer loop is search distance from the RR pointer, so the nearest requester wins.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int k = 0; k < N_MASTERS; k++) begin
            for (int i = 0; i < N_MASTERS; i++) begin
                if (!sel_found && req_valid[i] && (i == (int'(rr_q) + k) % N_MASTERS)) begin
                    sel_found = 1'b1;
                    sel_idx   = W_MASTER'(i);
                end
            end
        end
    end

    always_comb begin
        sel_write = 1'b0;
        sel_addr  = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (sel_idx == W_MASTER'(i)) begin
                sel_write = req_write[i];
                sel_addr  = req_addr[i*W_ADDR +: W_ADDR];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        rr_d          = rr_q;
        cmd_refresh_d = cmd_refresh_q;
        cmd_write_d   = cmd_write_q;
        cmd_addr_d    = cmd_addr_q;
        cmd_master_d  = cmd_master_q;
        case (state_q)
            S_IDLE: begin
                if (pend_q != '0) begin
                    cmd_refresh_d = 1'b1;
                    cmd_write_d   = 1'b0;
                    cmd_addr_d    = '0;
                    cmd_master_d  = '0;
                    state_d       = S_ISSUE;
                end else if (sel_found) begin
                    cmd_refresh_d = 1'b0;
                    cmd_write_d   = sel_write;
                    cmd_addr_d    = sel_addr;
                    cmd_master_d  = sel_idx;
                    state_d       = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (cmd_ready) begin
                    if (!cmd_refresh_q) begin
                        rr_d = (cmd_master_q == W_MASTER'(N_MASTERS - 1)) ? '0
                                                                          : cmd_master_q + W_MASTER'(1);
                    end
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (cmd_done) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A tick and a refresh accept in the same cycle cancel out, without touching overflow.
    always_comb begin
        refresh_cnt_d = (!cfg_refresh_en || tick) ? cfg_refresh_interval : refresh_cnt_q - 1'b1;
        pend_d        = pend_q;
        ovf_d         = ovf_q;
        if (tick && !refresh_accept) begin
            if (pend_q == PEND_MAX) begin
                ovf_d = 1'b1;
            end else begin
                pend_d = pend_q + 1'b1;
            end
        end else if (!tick && refresh_accept) begin
            pend_d = pend_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            rr_q          <= '0;
            cmd_refresh_q <= 1'b0;
            cmd_write_q   <= 1'b0;
            cmd_addr_q    <= '0;
            cmd_master_q  <= '0;
            refresh_cnt_q <= '0;
            pend_q        <= '0;
            ovf_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_q          <= rr_d;
            cmd_refresh_q <= cmd_refresh_d;
            cmd_write_q   <= cmd_write_d;
            cmd_addr_q    <= cmd_addr_d;
            cmd_master_q  <= cmd_master_d;
            refresh_cnt_q <= refresh_cnt_d;
            pend_q        <= pend_d;
            ovf_q         <= ovf_d;
        end
    end

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            req_ready[i] = accept && !cmd_refresh_q && (cmd_master_q == W_MASTER'(i));
        end
    end

    assign cmd_valid        = (state_q == S_ISSUE);
    assign cmd_refresh      = cmd_refresh_q;
    assign cmd_write        = cmd_write_q;
    assign cmd_addr         = cmd_addr_q;
    assign cmd_master       = cmd_master_q;
    assign refresh_pending  = pend_q;
    assign refresh_overflow = ovf_q;
    assign dbg_state        = state_q;

endmodule

// File: doc/sdram_burst_scheduler.md
Name: sdram_burst_scheduler

Overview:
- Sits between the per-master AHB-Lite burst front-ends and the SDRAM command/PHY engine.
- Decides which wrap-4 burst request, or auto-refresh, is issued next to the single SDRAM engine.
- Round-robin fairness between masters; refresh takes priority at burst boundaries.
- Generates periodic refresh requests from a programmable interval timer, with a saturating pending-refresh counter.

Parameters:
- N_MASTERS, 2, number of requesting masters (≥1).
- W_MASTER, 1, width of master index; must be ≥ clog2(N_MASTERS), minimum 1.
- W_ADDR, 25, byte address width of a burst request (16-byte aligned).
- W_REFRESH_CNT, 12, width of refresh interval counter.
- W_REFRESH_PEND, 3, width of pending-refresh counter; saturates at 2^W_REFRESH_PEND-1.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- req_valid  in  N_MASTERS  per-master burst request; held until req_ready
- req_write  in  N_MASTERS  per-master direction, 1=write
- req_addr  in  N_MASTERS*W_ADDR  per-master burst address; master i occupies slice i
- req_ready  out  N_MASTERS  one-hot pulse: request accepted by engine
- cmd_valid  out  1  command presented to SDRAM engine
- cmd_ready  in  1  engine accepts command
- cmd_refresh  out  1  command is auto-refresh; addr/write/master are don't-care
- cmd_write  out  1  burst direction
- cmd_addr  out  W_ADDR  burst address
- cmd_master  out  W_MASTER  index of granted master
- cmd_done  in  1  single-cycle pulse: engine has finished the accepted command
- cfg_refresh_en  in  1  enable refresh timer
- cfg_refresh_interval  in  W_REFRESH_CNT  refresh tick period minus 1
- refresh_pending  out  W_REFRESH_PEND  current pending-refresh count
- refresh_overflow  out  1  sticky: a tick arrived while pending was saturated

Behaviour:
- Reset (async, any time, including mid-burst):
  - All outputs 0; state = IDLE.
  - RR pointer = 0; refresh counter = 0; pending = 0.
  - In-flight engine command is abandoned; the engine is reset alongside.
- FSM states: IDLE, ISSUE, BUSY.
- IDLE, selection:
  - If pending > 0: latch a refresh command; cmd_refresh=1; go to ISSUE.
  - Else if any req_valid: pick first set bit searching from RR pointer upward with wrap; latch write, addr and index into cmd_*; go to ISSUE.
  - Else stay in IDLE.
- ISSUE:
  - cmd_valid=1, asserted the cycle after selection (req_valid→cmd_valid latency 1 cycle).
  - cmd_* stable while cmd_valid && !cmd_ready.
  - On cmd_valid && cmd_ready:
    - If a burst: req_ready[cmd_master]=1 in that same cycle (combinational from cmd_ready), and RR pointer ← (cmd_master+1) mod N_MASTERS.
    - If a refresh: pending decrements; no req_ready.
    - Go to BUSY; cmd_valid=0 next cycle.
- BUSY: wait for cmd_done, then go to IDLE. Next selection occurs in the IDLE cycle, so minimum accept-to-accept spacing is cmd_done + 2 cycles.
- A cmd_done pulse outside BUSY is ignored.
- Requesters must not drop req_valid before req_ready. A master whose req_valid is deasserted while latched behaves as undefined, and is flagged by the bench assertion.
- Refresh timer:
  - cfg_refresh_en=0: counter ← cfg_refresh_interval every cycle; no ticks; pending still drains.
  - cfg_refresh_en=1: if counter==0, tick and counter ← cfg_refresh_interval; else counter decrements. Tick period = interval+1 cycles.
  - The first tick occurs on the first enabled cycle after reset, because the counter resets to 0.
- Pending counter:
  - Tick alone: +1, saturating at max.
  - Tick while at max: refresh_overflow ← 1 (cleared only by rst); pending stays at max.
  - Refresh accept alone: −1.
  - Tick and accept in the same cycle: unchanged (overflow not set).
- Refresh pre-empts waiting masters only at IDLE. It never interrupts a latched burst (ISSUE) or an in-flight burst (BUSY).
- A refresh accept does not move the RR pointer.

Test Plan:
- Single master: req_valid[0]=1, addr=0x40, write=1, cmd_ready=1, refresh disabled → cmd_valid at cycle+1 with cmd_addr=0x40, cmd_write=1, cmd_master=0; req_ready=2'b01 same cycle; BUSY until cmd_done.
- Both masters request continuously, cmd_done 3 cycles after each accept → grants alternate 0,1,0,1; neither master waits more than one burst.
- cmd_ready held low 5 cycles in ISSUE while req_addr[1] changes → cmd_* unchanged; req_ready stays 0 until cmd_ready.
- cfg_refresh_interval=9, enable, no masters, cmd_ready=1, cmd_done 2 cycles after accept → refresh command every 10 cycles; pending returns to 0; overflow stays 0.
- cfg_refresh_interval=0, cmd_ready=0 → pending climbs 1..7 over 7 cycles, then overflow=1 and pending stays 7. Raise cmd_ready with ticks continuing → pending holds at 7 (tick and accept cancel).
- Assert rst while in BUSY with pending=3 → asynchronously cmd_valid=0, req_ready=0, pending=0, overflow=0. After release, master 0 is granted first.
